// File: rtl/chip_burst_sequencer.sv
// -----------------------------------------------------------------------------
// chip_burst_sequencer
//
// Splits 68040 line (burst) transfers into four single-longword cycles for the
// U712 chip RAM / register cycle logic, which cannot burst. Each beat is
// started with a TSn pulse and acknowledged to the CPU with one CPU_TAn pulse
// once U712 terminates it with TACKn. Non-line transfers run as one beat.
//
// Optional feature macro: BURST_TIMEOUT_EN
//   defined   -> 8-bit WAIT watchdog; on expiry CPU_TEAn pulses instead of
//                CPU_TAn and the remaining beats are dropped.
//   undefined -> no watchdog, CPU_TEAn tied high, WAIT holds indefinitely.
//
// Ports
//   CLK80       in   80 MHz clock, rising edge
//   RESETn      in   asynchronous active-low reset
//   CPU_TSn     in   CPU transfer start
//   CPU_RnW     in   CPU direction, valid with CPU_TSn
//   CPU_SIZ[1:0]in   CPU size, 2'b11 = line
//   CPU_A[1:0]  in   CPU address [3:2], starting longword
//   CHIPSPACEn  in   chip RAM / register space decode, low = selected
//   TACKn       in   U712 cycle termination
//   TSn         out  transfer start to U712 (2 cycles low per beat)
//   RnW_OUT     out  latched direction to U712
//   SIZ_OUT[1:0]out  size to U712 (longword on every line beat)
//   A_OUT[1:0]  out  longword address [3:2] to U712, wraps modulo 4
//   CPU_TAn     out  transfer acknowledge to CPU (2 cycles low per beat)
//   CPU_TEAn    out  transfer error acknowledge to CPU
//   BUSY        out  high whenever the sequencer is not idle
// -----------------------------------------------------------------------------
module chip_burst_sequencer #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       CLK80,
    input  logic       RESETn,
    input  logic       CPU_TSn,
    input  logic       CPU_RnW,
    input  logic [1:0] CPU_SIZ,
    input  logic [1:0] CPU_A,
    input  logic       CHIPSPACEn,
    input  logic       TACKn,
    output logic       TSn,
    output logic       RnW_OUT,
    output logic [1:0] SIZ_OUT,
    output logic [1:0] A_OUT,
    output logic       CPU_TAn,
    output logic       CPU_TEAn,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_ACK,
        S_GAP
    } state_t;

    state_t     state;
    logic       phase;   // second cycle of the 2-cycle START/ACK states
    logic [1:0] beats;   // beats remaining after the current one

`ifdef BURST_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic       err;     // current ACK phase reports an error, not a beat
    logic [7:0] wdog;
`else
    assign CPU_TEAn = 1'b1;
`endif

    logic line_req;
    assign line_req = (CPU_SIZ == 2'b11);

    always_ff @(posedge CLK80 or negedge RESETn) begin
        if (!RESETn) begin
            state    <= S_IDLE;
            phase    <= 1'b0;
            beats    <= 2'd0;
            TSn      <= 1'b1;
            RnW_OUT  <= 1'b1;
            SIZ_OUT  <= 2'b00;
            A_OUT    <= 2'b00;
            CPU_TAn  <= 1'b1;
            BUSY     <= 1'b0;
`ifdef BURST_TIMEOUT_EN
            err      <= 1'b0;
            wdog     <= 8'd0;
            CPU_TEAn <= 1'b1;
`endif
        end else begin
            // The strobes follow the state one cycle late, so A_OUT/SIZ_OUT/
            // RnW_OUT (updated on the state change) lead TSn by one cycle.
            // NOTE: non-blocking assignments here, so every right-hand side
            // reads the pre-edge state regardless of statement order.
            TSn <= (state != S_START);
`ifdef BURST_TIMEOUT_EN
            CPU_TAn  <= !((state == S_ACK) && !err);
            CPU_TEAn <= !((state == S_ACK) && err);
`else
            CPU_TAn  <= (state != S_ACK);
`endif

            case (state)
                S_IDLE: begin
                    if (!CPU_TSn && !CHIPSPACEn) begin
                        state   <= S_START;
                        phase   <= 1'b0;
                        BUSY    <= 1'b1;
                        RnW_OUT <= CPU_RnW;
                        A_OUT   <= CPU_A;
                        SIZ_OUT <= line_req ? 2'b00 : CPU_SIZ;
                        beats   <= line_req ? 2'd3 : 2'd0;
                    end
                end

                // TACKn is deliberately not looked at here; an early
                // termination on the last START cycle is not counted.
                S_START: begin
                    phase <= ~phase;
                    if (phase) begin
                        state <= S_WAIT;
`ifdef BURST_TIMEOUT_EN
                        wdog  <= 8'd0;
`endif
                    end
                end

                S_WAIT: begin
                    if (!TACKn) begin
                        state <= S_ACK;
                        phase <= 1'b0;
                    end
`ifdef BURST_TIMEOUT_EN
                    else if (wdog == WDOG_LAST) begin
                        // Error acknowledge replaces the beat; zeroing the
                        // counter makes GAP end the transfer.
                        state <= S_ACK;
                        phase <= 1'b0;
                        err   <= 1'b1;
                        beats <= 2'd0;
                    end else begin
                        wdog <= wdog + 8'd1;
                    end
`endif
                end

                S_ACK: begin
                    phase <= ~phase;
                    if (phase) begin
                        state <= S_GAP;
                    end
                end

                S_GAP: begin
                    if (TACKn) begin
                        if (beats == 2'd0) begin
                            state <= S_IDLE;
                            BUSY  <= 1'b0;
`ifdef BURST_TIMEOUT_EN
                            err   <= 1'b0;
`endif
                        end else begin
                            beats <= beats - 2'd1;
                            A_OUT <= A_OUT + 2'd1;   // 68040 wrap order
                            state <= S_START;
                            phase <= 1'b0;
                        end
                    end
                end

                default: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_chip_burst_sequencer.sv
`timescale 1ns/1ps
// Testbench for chip_burst_sequencer. All activity advances through tick(),
// which samples the DUT on the falling edge, scores TSn/CPU_TAn/CPU_TEAn
// pulses against a queue of expected beats and plays the U712 responder.
module tb_chip_burst_sequencer;

    localparam int TIMEOUT_CYCLES = 255;

    logic       CLK80      = 1'b0;
    logic       RESETn     = 1'b0;
    logic       CPU_TSn    = 1'b1;
    logic       CPU_RnW    = 1'b1;
    logic [1:0] CPU_SIZ    = 2'b00;
    logic [1:0] CPU_A      = 2'b00;
    logic       CHIPSPACEn = 1'b1;
    logic       TACKn      = 1'b1;
    logic       TSn;
    logic       RnW_OUT;
    logic [1:0] SIZ_OUT;
    logic [1:0] A_OUT;
    logic       CPU_TAn;
    logic       CPU_TEAn;
    logic       BUSY;

    always #5 CLK80 = ~CLK80;

    chip_burst_sequencer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .CLK80      (CLK80),
        .RESETn     (RESETn),
        .CPU_TSn    (CPU_TSn),
        .CPU_RnW    (CPU_RnW),
        .CPU_SIZ    (CPU_SIZ),
        .CPU_A      (CPU_A),
        .CHIPSPACEn (CHIPSPACEn),
        .TACKn      (TACKn),
        .TSn        (TSn),
        .RnW_OUT    (RnW_OUT),
        .SIZ_OUT    (SIZ_OUT),
        .A_OUT      (A_OUT),
        .CPU_TAn    (CPU_TAn),
        .CPU_TEAn   (CPU_TEAn),
        .BUSY       (BUSY)
    );

    typedef struct packed {
        logic [1:0] a;
        logic [1:0] siz;
        logic       rnw;
    } beat_t;

    beat_t exp_q[$];
    beat_t cur_beat = '0;

    int checks   = 0;
    int failures = 0;

    // pulse monitor
    int   cyc = 0;
    int   ts_pulses = 0, ta_pulses = 0, tea_pulses = 0;
    int   ts_len = 0, ta_len = 0, tea_len = 0;
    int   ts_fall_cyc = 0, tea_fall_cyc = 0;
    logic ts_prev = 1'b1, ta_prev = 1'b1, tea_prev = 1'b1;
    logic [1:0] a_prev = 2'b00, siz_prev = 2'b00;
    logic rnw_prev = 1'b1;

    // U712 responder model
    bit resp_en   = 1'b0;
    int ack_delay = 0;
    int ack_limit = 1000000;
    int acked     = 0;
    int r_state   = 0;   // 0 idle, 1 delaying, 2 holding TACKn low
    int r_dly     = 0;
    int inject_n  = 0;   // cycles of unsolicited TACKn low

    task automatic tick();
        bit ts_fell;
        @(negedge CLK80);
        cyc++;
        ts_fell = 1'b0;
        if (RESETn) begin
            if (!TSn && ts_prev) begin
                ts_fell = 1'b1;
                ts_pulses++;
                ts_fall_cyc = cyc;
                ts_len = 1;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL ts_unexpected: TSn fell at cycle %0d, no beat expected", cyc);
                end else begin
                    cur_beat = exp_q.pop_front();
                    if ({A_OUT, SIZ_OUT, RnW_OUT} !== cur_beat) begin
                        failures++;
                        $display("FAIL beat_fields: A/SIZ/RnW=%b got, %b required", {A_OUT, SIZ_OUT, RnW_OUT}, cur_beat);
                    end
                    checks++;
                    if ({a_prev, siz_prev, rnw_prev} !== cur_beat) begin
                        failures++;
                        $display("FAIL beat_setup: A/SIZ/RnW one cycle before TSn=%b got, %b required", {a_prev, siz_prev, rnw_prev}, cur_beat);
                    end
                end
            end else if (!TSn) begin
                ts_len++;
            end else if (!ts_prev) begin
                checks++;
                if (ts_len != 2) begin
                    failures++;
                    $display("FAIL ts_width: TSn low %0d cycles, required 2", ts_len);
                end
            end

            if (!CPU_TAn && ta_prev) begin
                ta_pulses++;
                ta_len = 1;
                checks++;
                if ({A_OUT, SIZ_OUT, RnW_OUT} !== cur_beat) begin
                    failures++;
                    $display("FAIL beat_hold: A/SIZ/RnW at CPU_TAn=%b got, %b required", {A_OUT, SIZ_OUT, RnW_OUT}, cur_beat);
                end
            end else if (!CPU_TAn) begin
                ta_len++;
            end else if (!ta_prev) begin
                checks++;
                if (ta_len != 2) begin
                    failures++;
                    $display("FAIL ta_width: CPU_TAn low %0d cycles, required 2", ta_len);
                end
            end

            if (!CPU_TEAn && tea_prev) begin
                tea_pulses++;
                tea_fall_cyc = cyc;
                tea_len = 1;
            end else if (!CPU_TEAn) begin
                tea_len++;
            end else if (!tea_prev) begin
                checks++;
                if (tea_len != 2) begin
                    failures++;
                    $display("FAIL tea_width: CPU_TEAn low %0d cycles, required 2", tea_len);
                end
            end
        end
        ts_prev  = TSn;
        ta_prev  = CPU_TAn;
        tea_prev = CPU_TEAn;
        a_prev   = A_OUT;
        siz_prev = SIZ_OUT;
        rnw_prev = RnW_OUT;

        if (r_state == 2 && !CPU_TAn) begin
            r_state = 0;
            acked++;
        end
        if (ts_fell && resp_en && acked < ack_limit) begin
            r_state = 1;
            r_dly   = ack_delay;
        end
        if (r_state == 1) begin
            if (r_dly == 0) r_state = 2;
            else r_dly--;
        end
        TACKn = !(r_state == 2 || inject_n > 0);
        if (inject_n > 0) inject_n--;
    endtask

    task automatic cpu_xfer(input logic rnw, input logic [1:0] siz, input logic [1:0] a,
                            input logic cs_n, input bit accept);
        beat_t b;
        if (accept) begin
            if (siz == 2'b11) begin
                for (int i = 0; i < 4; i++) begin
                    b.a = a + 2'(i); b.siz = 2'b00; b.rnw = rnw;
                    exp_q.push_back(b);
                end
            end else begin
                b.a = a; b.siz = siz; b.rnw = rnw;
                exp_q.push_back(b);
            end
        end
        CPU_TSn = 1'b0; CPU_RnW = rnw; CPU_SIZ = siz; CPU_A = a; CHIPSPACEn = cs_n;
        tick();
        tick();
        CPU_TSn = 1'b1; CHIPSPACEn = 1'b1;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n;
        n = 0;
        while (BUSY !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (BUSY !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_timeout: BUSY=%b after %0d cycles, required 0", name, BUSY, n);
        end
    endtask

    task automatic test_reset();
        bit busy_seen;
        RESETn = 1'b0;
        repeat (3) tick();
        checks++; if (TSn !== 1'b1)      begin failures++; $display("FAIL rst_tsn: %b got, 1 required", TSn); end
        checks++; if (CPU_TAn !== 1'b1)  begin failures++; $display("FAIL rst_tan: %b got, 1 required", CPU_TAn); end
        checks++; if (CPU_TEAn !== 1'b1) begin failures++; $display("FAIL rst_tean: %b got, 1 required", CPU_TEAn); end
        checks++; if (BUSY !== 1'b0)     begin failures++; $display("FAIL rst_busy: %b got, 0 required", BUSY); end
        checks++; if (RnW_OUT !== 1'b1)  begin failures++; $display("FAIL rst_rnw: %b got, 1 required", RnW_OUT); end
        checks++; if (SIZ_OUT !== 2'b00) begin failures++; $display("FAIL rst_siz: %b got, 00 required", SIZ_OUT); end
        checks++; if (A_OUT !== 2'b00)   begin failures++; $display("FAIL rst_a: %b got, 00 required", A_OUT); end
        RESETn = 1'b1;
        busy_seen = 1'b0;
        repeat (8) begin
            tick();
            if (BUSY !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (busy_seen) begin failures++; $display("FAIL rst_idle_busy: BUSY rose with no CPU_TSn, required 0"); end
        checks++; if (ts_pulses != 0) begin failures++; $display("FAIL rst_idle_ts: %0d TSn pulses, 0 required", ts_pulses); end
    endtask

    task automatic test_single_read();
        int ts0, ta0;
        ts0 = ts_pulses; ta0 = ta_pulses;
        resp_en = 1'b1; ack_delay = 5;
        cpu_xfer(1'b1, 2'b00, 2'b01, 1'b0, 1'b1);
        wait_idle(100, "single");
        checks++; if (ts_pulses - ts0 != 1) begin failures++; $display("FAIL single_ts_count: %0d got, 1 required", ts_pulses - ts0); end
        checks++; if (ta_pulses - ta0 != 1) begin failures++; $display("FAIL single_ta_count: %0d got, 1 required", ta_pulses - ta0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL single_left: %0d beats outstanding, 0 required", exp_q.size()); end
    endtask

    task automatic test_line_write();
        int ts0, ta0;
        ts0 = ts_pulses; ta0 = ta_pulses;
        resp_en = 1'b1; ack_delay = 1;
        cpu_xfer(1'b0, 2'b11, 2'b10, 1'b0, 1'b1);
        wait_idle(200, "line");
        checks++; if (ts_pulses - ts0 != 4) begin failures++; $display("FAIL line_ts_count: %0d got, 4 required", ts_pulses - ts0); end
        checks++; if (ta_pulses - ta0 != 4) begin failures++; $display("FAIL line_ta_count: %0d got, 4 required", ta_pulses - ta0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL line_left: %0d beats outstanding, 0 required", exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        int ts0, ta0;
        logic       rnw_t[3] = '{1'b1, 1'b0, 1'b1};
        logic [1:0] siz_t[3] = '{2'b01, 2'b10, 2'b11};
        logic [1:0] a_t[3]   = '{2'b11, 2'b00, 2'b11};
        ts0 = ts_pulses; ta0 = ta_pulses;
        resp_en = 1'b1; ack_delay = 0;
        for (int i = 0; i < 3; i++) begin
            cpu_xfer(rnw_t[i], siz_t[i], a_t[i], 1'b0, 1'b1);
            wait_idle(200, "b2b");
        end
        checks++; if (ts_pulses - ts0 != 6) begin failures++; $display("FAIL b2b_ts_count: %0d got, 6 required", ts_pulses - ts0); end
        checks++; if (ta_pulses - ta0 != 6) begin failures++; $display("FAIL b2b_ta_count: %0d got, 6 required", ta_pulses - ta0); end
    endtask

    task automatic test_ignored();
        int ts0, ta0;
        bit busy_seen;
        // CPU_TSn outside chip space
        ts0 = ts_pulses;
        cpu_xfer(1'b1, 2'b00, 2'b00, 1'b1, 1'b0);
        busy_seen = 1'b0;
        repeat (6) begin
            tick();
            if (BUSY !== 1'b0) busy_seen = 1'b1;
        end
        checks++; if (busy_seen) begin failures++; $display("FAIL ign_cs_busy: BUSY rose, 0 required"); end
        checks++; if (ts_pulses != ts0) begin failures++; $display("FAIL ign_cs_ts: %0d TSn pulses, 0 required", ts_pulses - ts0); end
        // unsolicited TACKn while idle
        ta0 = ta_pulses;
        inject_n = 3;
        repeat (8) tick();
        checks++; if (ta_pulses != ta0) begin failures++; $display("FAIL ign_tack_ta: %0d CPU_TAn pulses, 0 required", ta_pulses - ta0); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ign_tack_busy: %b got, 0 required", BUSY); end
        // a second CPU_TSn while a transfer is in WAIT
        ts0 = ts_pulses; ta0 = ta_pulses;
        resp_en = 1'b1; ack_delay = 8;
        cpu_xfer(1'b1, 2'b00, 2'b10, 1'b0, 1'b1);
        repeat (2) tick();
        cpu_xfer(1'b0, 2'b11, 2'b01, 1'b0, 1'b0);
        wait_idle(100, "ign_busy");
        repeat (4) tick();
        checks++; if (ts_pulses - ts0 != 1) begin failures++; $display("FAIL ign_busy_ts: %0d got, 1 required", ts_pulses - ts0); end
        checks++; if (ta_pulses - ta0 != 1) begin failures++; $display("FAIL ign_busy_ta: %0d got, 1 required", ta_pulses - ta0); end
        checks++; if (BUSY !== 1'b0) begin failures++; $display("FAIL ign_busy_idle: BUSY=%b got, 0 required", BUSY); end
    endtask

    task automatic test_reset_mid();
        int ts0, ta0, n;
        ts0 = ts_pulses; ta0 = ta_pulses;
        resp_en = 1'b1; ack_delay = 2; ack_limit = acked + 1;
        cpu_xfer(1'b1, 2'b11, 2'b01, 1'b0, 1'b1);
        n = 0;
        while (ts_pulses - ts0 < 2 && n < 200) begin
            tick();
            n++;
        end
        checks++; if (ts_pulses - ts0 != 2) begin failures++; $display("FAIL mid_beat2: %0d TSn pulses, 2 required", ts_pulses - ts0); end
        repeat (4) tick();
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL mid_wait_busy: %b got, 1 required", BUSY); end
        #2 RESETn = 1'b0;
        #1;
        checks++; if (TSn !== 1'b1)     begin failures++; $display("FAIL mid_rst_tsn: %b got, 1 required", TSn); end
        checks++; if (CPU_TAn !== 1'b1) begin failures++; $display("FAIL mid_rst_tan: %b got, 1 required", CPU_TAn); end
        checks++; if (BUSY !== 1'b0)    begin failures++; $display("FAIL mid_rst_busy: %b got, 0 required", BUSY); end
        checks++; if (A_OUT !== 2'b00)  begin failures++; $display("FAIL mid_rst_a: %b got, 00 required", A_OUT); end
        checks++; if (ta_pulses - ta0 != 1) begin failures++; $display("FAIL mid_ta_count: %0d got, 1 required", ta_pulses - ta0); end
        checks++; if (exp_q.size() != 2) begin failures++; $display("FAIL mid_left: %0d beats outstanding, 2 required", exp_q.size()); end
        exp_q.delete();
        tick();
        RESETn = 1'b1;
        ack_limit = 1000000;
        tick();
        ts0 = ts_pulses; ta0 = ta_pulses;
        cpu_xfer(1'b0, 2'b00, 2'b11, 1'b0, 1'b1);
        wait_idle(100, "mid_after");
        checks++; if (ts_pulses - ts0 != 1) begin failures++; $display("FAIL mid_after_ts: %0d got, 1 required", ts_pulses - ts0); end
        checks++; if (ta_pulses - ta0 != 1) begin failures++; $display("FAIL mid_after_ta: %0d got, 1 required", ta_pulses - ta0); end
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL mid_after_left: %0d outstanding, 0 required", exp_q.size()); end
    endtask

    task automatic test_timeout();
        int ta0, tea0;
        ta0 = ta_pulses; tea0 = tea_pulses;
        resp_en = 1'b0;
        cpu_xfer(1'b1, 2'b00, 2'b11, 1'b0, 1'b1);
`ifdef BURST_TIMEOUT_EN
        begin
            int n;
            n = 0;
            while (tea_pulses == tea0 && n < 400) begin
                tick();
                n++;
            end
            checks++; if (tea_pulses - tea0 != 1) begin failures++; $display("FAIL to_tea_count: %0d got, 1 required", tea_pulses - tea0); end
            checks++; if (tea_fall_cyc - ts_fall_cyc != TIMEOUT_CYCLES + 2) begin
                failures++;
                $display("FAIL to_latency: TEAn fell %0d cycles after TSn, %0d required", tea_fall_cyc - ts_fall_cyc, TIMEOUT_CYCLES + 2);
            end
            wait_idle(20, "to");
            repeat (2) tick();
            checks++; if (ta_pulses != ta0) begin failures++; $display("FAIL to_ta: %0d CPU_TAn pulses, 0 required", ta_pulses - ta0); end
        end
`else
        repeat (300) tick();
        checks++; if (tea_pulses != tea0) begin failures++; $display("FAIL to_tea_tied: %0d CPU_TEAn pulses, 0 required", tea_pulses - tea0); end
        checks++; if (CPU_TEAn !== 1'b1) begin failures++; $display("FAIL to_tea_level: %b got, 1 required", CPU_TEAn); end
        checks++; if (BUSY !== 1'b1) begin failures++; $display("FAIL to_busy_hold: %b got, 1 required", BUSY); end
        checks++; if (ta_pulses != ta0) begin failures++; $display("FAIL to_ta: %0d CPU_TAn pulses, 0 required", ta_pulses - ta0); end
        RESETn = 1'b0;
        tick();
        RESETn = 1'b1;
        tick();
`endif
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL to_left: %0d outstanding, 0 required", exp_q.size()); end
        resp_en = 1'b1;
    endtask

    initial begin
        tick();
        test_reset();
        test_single_read();
        test_line_write();
        test_back_to_back();
        test_ignored();
        test_reset_mid();
        test_timeout();
        repeat (4) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/chip_burst_sequencer.md
# chip_burst_sequencer

- Sits between the 68040 local bus and the U712 chip RAM/register cycle logic.
- Chip RAM and register space cycles cannot burst, so this block splits each CPU line (burst) transfer into four single-longword cycles, presented to U712 as ordinary transfer starts.
- It counts U712 terminations and returns one CPU transfer acknowledge per beat.
- Non-line transfers pass through as single-beat cycles.

## Interface
Parameters:
- TIMEOUT_CYCLES, 255: CLK80 cycles to wait for TACKn before bus-error abort. Used only with the timeout feature.

Ports:
- CLK80  in  1  80 MHz system clock; all logic on rising edge.
- RESETn  in  1  asynchronous active-low reset.
- CPU_TSn  in  1  CPU transfer start, low for 2 CLK80 cycles.
- CPU_RnW  in  1  CPU read/write, valid with CPU_TSn.
- CPU_SIZ  in  2  CPU transfer size; 2'b11 = line.
- CPU_A  in  2  CPU address bits [3:2], the starting longword.
- CHIPSPACEn  in  1  decoded chip RAM or register space, low = selected.
- TACKn  in  1  U712 cycle termination, low ≥1 CLK80.
- TSn  out  1  transfer start to U712.
- RnW_OUT  out  1  latched direction to U712.
- SIZ_OUT  out  2  size to U712.
- A_OUT  out  2  longword address [3:2] to U712.
- CPU_TAn  out  1  transfer acknowledge to CPU.
- CPU_TEAn  out  1  transfer error acknowledge to CPU.
- BUSY  out  1  high while a transfer is in progress.

## Operation
- States:
  - IDLE
  - START: TSn low, 2 cycles
  - WAIT: await TACKn low
  - ACK: CPU_TAn low, 2 cycles
  - GAP: await TACKn high
- IDLE → START when CPU_TSn and CHIPSPACEn are both sampled low.
  - Latch CPU_RnW, CPU_A and CPU_SIZ.
  - Load the beat counter: 3 if CPU_SIZ = 2'b11, else 0.
- SIZ_OUT:
  - Line transfers drive 2'b00 (longword) on every beat.
  - Non-line transfers pass the latched CPU_SIZ through.
- A_OUT starts at the latched CPU_A and increments by 1 per beat, wrapping modulo 4 (68040 wrap order). Example: start 2'b10 gives 10, 11, 00, 01.
- START → WAIT after its 2 cycles.
- WAIT → ACK when TACKn is sampled low.
- ACK → GAP after its 2 cycles.
- GAP, once TACKn is sampled high:
  - beat counter = 0 → IDLE
  - otherwise decrement the counter, advance A_OUT, → START
- BUSY is high in every state except IDLE.
- CPU_TSn sampled while not in IDLE is ignored.
- CPU_TSn with CHIPSPACEn high is ignored; the block stays in IDLE.
- TACKn low outside WAIT is ignored (no spurious acknowledge).
- When TACKn low arrives on the last START cycle, it is not counted; the block waits for TACKn in WAIT.

## Timing
- Reset values: TSn = 1, CPU_TAn = 1, CPU_TEAn = 1, BUSY = 0, RnW_OUT = 1, SIZ_OUT = 2'b00, A_OUT = 2'b00; state = IDLE; beat counter = 0.
- All outputs are registered.
- Latency, with CPU_TSn sampled low at edge N:
  - TSn is low from edge N+1 through edge N+2.
  - TACKn sampled low at edge M gives CPU_TAn low from edge M+1 through edge M+2.
- Minimum per beat: 2 (START) + 1 (WAIT) + 2 (ACK) + 1 (GAP) = 6 CLK80 cycles.
- A_OUT, SIZ_OUT and RnW_OUT are stable from one cycle before TSn falls until TACKn is sampled high in GAP.
- RESETn low mid-burst: all outputs return to reset values asynchronously and remaining beats are discarded. No CPU_TAn is issued for an incomplete beat.

## Configuration
- BURST_TIMEOUT_EN defined:
  - An 8-bit watchdog clears on entry to WAIT and counts while in WAIT.
  - When it reaches TIMEOUT_CYCLES, the block drives CPU_TEAn low for 2 cycles instead of CPU_TAn, discards remaining beats, and returns to IDLE.
- BURST_TIMEOUT_EN undefined:
  - No watchdog logic is present.
  - CPU_TEAn is tied high.
  - WAIT holds indefinitely.

## Test plan
- Reset: hold RESETn low → all outputs at reset values. Release; with no CPU_TSn, BUSY stays 0.
- Single longword read: CPU_SIZ = 00, CPU_A = 01, CPU_TSn low, TACKn low 5 cycles later → one TSn pulse (2 cycles), A_OUT = 01, SIZ_OUT = 00, one CPU_TAn pulse (2 cycles), then IDLE.
- Line write from CPU_A = 10: CPU_SIZ = 11, U712 model acknowledges each beat → exactly 4 TSn and 4 CPU_TAn pulses, A_OUT sequence 10, 11, 00, 01, SIZ_OUT = 00, RnW_OUT = 0 throughout.
- Ignored inputs: CHIPSPACEn high during CPU_TSn → no TSn and BUSY = 0. TACKn pulse injected in IDLE → no CPU_TAn.
- Reset mid-burst: assert RESETn during beat 2 WAIT → TSn, CPU_TAn and BUSY return to idle values within the same cycle. A subsequent single transfer completes normally.
- Timeout (BURST_TIMEOUT_EN, TIMEOUT_CYCLES = 255): TACKn held high → CPU_TEAn low 2 cycles after 255 WAIT cycles, no CPU_TAn, back to IDLE. Without the macro: CPU_TEAn stays 1 and BUSY stays 1.
